// File: rtl/sys_ctrl_if.sv
// Bus bundle between the command sequencer and its RegFile, ALU and TX FIFO neighbours.
// master = sequencer side, slave = peripheral/stimulus side.
interface sys_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [ADDR_WIDTH-1:0]   RF_Address;
  logic [DATA_WIDTH-1:0]   RF_WrData;
  logic                    RF_WrEn;
  logic                    RF_RdEn;
  logic [DATA_WIDTH-1:0]   RF_RdData;
  logic                    RF_RdData_Vaild;
  logic [FUN_WIDTH-1:0]    ALU_FUN;
  logic                    ALU_EN;
  logic                    ALU_CLK_EN;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VALID;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    FIFO_FULL;
  logic                    BUSY;
  logic                    CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_Vaild, ALU_OUT, ALU_OUT_VALID, FIFO_FULL,
    output RF_Address, RF_WrData, RF_WrEn, RF_RdEn, ALU_FUN, ALU_EN, ALU_CLK_EN,
           TX_P_DATA, TX_D_VLD, BUSY, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_Vaild, ALU_OUT, ALU_OUT_VALID, FIFO_FULL,
    input  RF_Address, RF_WrData, RF_WrEn, RF_RdEn, ALU_FUN, ALU_EN, ALU_CLK_EN,
           TX_P_DATA, TX_D_VLD, BUSY, CMD_ERR
  );
endinterface

// File: rtl/sys_ctrl.sv
// Command sequencer: decodes RX command frames into RegFile/ALU operations and
// pushes response bytes into the TX FIFO. All outputs are registered.
module sys_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input logic         i_clk,
  input logic         i_rst,
  sys_ctrl_if.master  io_bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_ADDR  = 4'd1;
  localparam logic [3:0] S_WR_DATA  = 4'd2;
  localparam logic [3:0] S_RD_ADDR  = 4'd3;
  localparam logic [3:0] S_RD_WAIT  = 4'd4;
  localparam logic [3:0] S_TX_RF    = 4'd5;
  localparam logic [3:0] S_OP_A     = 4'd6;
  localparam logic [3:0] S_OP_B     = 4'd7;
  localparam logic [3:0] S_ALU_FN   = 4'd8;
  localparam logic [3:0] S_ALU_GO   = 4'd9;
  localparam logic [3:0] S_ALU_WAIT = 4'd10;
  localparam logic [3:0] S_TX_LSB   = 4'd11;
  localparam logic [3:0] S_TX_MSB   = 4'd12;

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

  localparam int            CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  logic [3:0]            r_state;
  logic [3:0]            w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_wr_en;
  logic                  r_rd_en;
  logic [FUN_WIDTH-1:0]  r_fun;
  logic                  r_alu_en;
  logic                  r_clk_en;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [DATA_WIDTH-1:0] r_msb;
  logic                  r_tx_vld;
  logic                  r_busy;
  logic                  r_cmd_err;

  logic                  w_rx_vld;
  logic [DATA_WIDTH-1:0] w_rx;
  logic                  w_full;
  logic                  w_timeout;
  logic                  w_wait_state;

  assign w_rx_vld     = io_bus.RX_D_VLD;
  assign w_rx         = io_bus.RX_P_DATA;
  assign w_full       = io_bus.FIFO_FULL;
  assign w_timeout    = (r_cnt == C_LAST);
  assign w_wait_state = (r_state == S_RD_WAIT) || (r_state == S_ALU_WAIT);

  // A valid response beats a timeout that lands in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (w_rx_vld) begin
          case (w_rx)
            CMD_WR:     w_state_nxt = S_WR_ADDR;
            CMD_RD:     w_state_nxt = S_RD_ADDR;
            CMD_ALU_OP: w_state_nxt = S_OP_A;
            CMD_ALU:    w_state_nxt = S_ALU_FN;
            default:    w_state_nxt = S_IDLE;
          endcase
        end
      S_WR_ADDR:  if (w_rx_vld) w_state_nxt = S_WR_DATA;
      S_WR_DATA:  if (w_rx_vld) w_state_nxt = S_IDLE;
      S_RD_ADDR:  if (w_rx_vld) w_state_nxt = S_RD_WAIT;
      S_RD_WAIT:
        if (io_bus.RF_RdData_Vaild) w_state_nxt = S_TX_RF;
        else if (w_timeout)         w_state_nxt = S_IDLE;
      S_TX_RF:    if (!w_full) w_state_nxt = S_IDLE;
      S_OP_A:     if (w_rx_vld) w_state_nxt = S_OP_B;
      S_OP_B:     if (w_rx_vld) w_state_nxt = S_ALU_FN;
      S_ALU_FN:   if (w_rx_vld) w_state_nxt = S_ALU_GO;
      S_ALU_GO:   w_state_nxt = S_ALU_WAIT;
      S_ALU_WAIT:
        if (io_bus.ALU_OUT_VALID) w_state_nxt = S_TX_LSB;
        else if (w_timeout)       w_state_nxt = S_IDLE;
      S_TX_LSB:   if (!w_full) w_state_nxt = S_TX_MSB;
      S_TX_MSB:   if (!w_full) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // TX_P_DATA only changes when a byte is actually pushed or captured, so it stays put while the FIFO is full.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_fun     <= '0;
      r_alu_en  <= 1'b0;
      r_clk_en  <= 1'b0;
      r_tx_data <= '0;
      r_msb     <= '0;
      r_tx_vld  <= 1'b0;
      r_busy    <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_alu_en  <= 1'b0;
      r_tx_vld  <= 1'b0;
      r_cmd_err <= 1'b0;

      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_wait_state)      r_cnt <= r_cnt + 1'b1;

      case (r_state)
        S_IDLE:
          if (w_rx_vld && (w_state_nxt == S_IDLE)) r_cmd_err <= 1'b1;
        S_WR_ADDR:
          if (w_rx_vld) r_addr <= w_rx[ADDR_WIDTH-1:0];
        S_WR_DATA:
          if (w_rx_vld) begin
            r_wr_data <= w_rx;
            r_wr_en   <= 1'b1;
          end
        S_RD_ADDR:
          if (w_rx_vld) begin
            r_addr  <= w_rx[ADDR_WIDTH-1:0];
            r_rd_en <= 1'b1;
          end
        S_RD_WAIT:
          if (io_bus.RF_RdData_Vaild) r_tx_data <= io_bus.RF_RdData;
          else if (w_timeout)         r_cmd_err <= 1'b1;
        S_TX_RF, S_TX_LSB:
          if (!w_full) r_tx_vld <= 1'b1;
        S_TX_MSB:
          if (!w_full) begin
            r_tx_data <= r_msb;
            r_tx_vld  <= 1'b1;
          end
        S_OP_A:
          if (w_rx_vld) begin
            r_addr    <= ADDR_WIDTH'(0);
            r_wr_data <= w_rx;
            r_wr_en   <= 1'b1;
          end
        S_OP_B:
          if (w_rx_vld) begin
            r_addr    <= ADDR_WIDTH'(1);
            r_wr_data <= w_rx;
            r_wr_en   <= 1'b1;
          end
        S_ALU_FN:
          if (w_rx_vld) begin
            r_fun    <= w_rx[FUN_WIDTH-1:0];
            r_clk_en <= 1'b1;
          end
        S_ALU_GO:
          r_alu_en <= 1'b1;
        S_ALU_WAIT:
          if (io_bus.ALU_OUT_VALID) begin
            r_tx_data <= io_bus.ALU_OUT[DATA_WIDTH-1:0];
            r_msb     <= io_bus.ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
            r_clk_en  <= 1'b0;
          end else if (w_timeout) begin
            r_cmd_err <= 1'b1;
            r_clk_en  <= 1'b0;
          end
        default: ;
      endcase
    end
  end

  assign io_bus.RF_Address = r_addr;
  assign io_bus.RF_WrData  = r_wr_data;
  assign io_bus.RF_WrEn    = r_wr_en;
  assign io_bus.RF_RdEn    = r_rd_en;
  assign io_bus.ALU_FUN    = r_fun;
  assign io_bus.ALU_EN     = r_alu_en;
  assign io_bus.ALU_CLK_EN = r_clk_en;
  assign io_bus.TX_P_DATA  = r_tx_data;
  assign io_bus.TX_D_VLD   = r_tx_vld;
  assign io_bus.BUSY       = r_busy;
  assign io_bus.CMD_ERR    = r_cmd_err;

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl: drives command frames byte by byte and checks
// strobes, FIFO traffic and error pulses against hand-computed values.
module tb_sys_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sys_ctrl_if bus ();

  sys_ctrl dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  int wrCnt    = 0;
  int rdCnt    = 0;
  int aluEnCnt = 0;
  int txCnt    = 0;
  int errCnt   = 0;
  int fullViol = 0;
  logic [7:0] wrAddrLog [0:63];
  logic [7:0] wrDataLog [0:63];
  logic [7:0] txLog     [0:63];

  // Outputs are one-cycle pulses, so sampling once per cycle counts each pulse once.
  always @(negedge clk) begin
    if (bus.RF_WrEn) begin
      wrAddrLog[wrCnt % 64] = 8'(bus.RF_Address);
      wrDataLog[wrCnt % 64] = bus.RF_WrData;
      wrCnt = wrCnt + 1;
    end
    if (bus.RF_RdEn) rdCnt = rdCnt + 1;
    if (bus.ALU_EN) aluEnCnt = aluEnCnt + 1;
    if (bus.CMD_ERR) errCnt = errCnt + 1;
    if (bus.TX_D_VLD) begin
      txLog[txCnt % 64] = bus.TX_P_DATA;
      txCnt = txCnt + 1;
      if (bus.FIFO_FULL) fullViol = fullViol + 1;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    waitCycles(1);
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitTx(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (txCnt >= target) break;
      waitCycles(1);
    end
  endtask

  int wr0, rd0, ae0, tx0, err0, n;

  initial begin
    rst = 1'b1;
    bus.RX_P_DATA       = '0;
    bus.RX_D_VLD        = 1'b0;
    bus.RF_RdData       = '0;
    bus.RF_RdData_Vaild = 1'b0;
    bus.ALU_OUT         = '0;
    bus.ALU_OUT_VALID   = 1'b0;
    bus.FIFO_FULL       = 1'b0;
    waitCycles(3);

    checkOutput("rstBusy",    bus.BUSY, 0);
    checkOutput("rstCmdErr",  bus.CMD_ERR, 0);
    checkOutput("rstTxVld",   bus.TX_D_VLD, 0);
    checkOutput("rstClkEn",   bus.ALU_CLK_EN, 0);
    checkOutput("rstAddr",    bus.RF_Address, 0);
    checkOutput("rstTxData",  bus.TX_P_DATA, 0);
    rst = 1'b0;
    waitCycles(1);

    $display("[TB] RF write AA,05,3C");
    wr0 = wrCnt; tx0 = txCnt;
    applyStimulus(8'hAA);
    checkOutput("wrBusyHigh", bus.BUSY, 1);
    applyStimulus(8'h05);
    applyStimulus(8'h3C);
    checkOutput("wrEnPulse", bus.RF_WrEn, 1);
    waitCycles(2);
    checkOutput("wrCount", wrCnt - wr0, 1);
    checkOutput("wrAddr",  wrAddrLog[wr0 % 64], 8'h05);
    checkOutput("wrData",  wrDataLog[wr0 % 64], 8'h3C);
    checkOutput("wrNoTx",  txCnt - tx0, 0);
    checkOutput("wrBusyLow", bus.BUSY, 0);

    $display("[TB] RF read BB,02 -> 7E");
    rd0 = rdCnt; tx0 = txCnt;
    applyStimulus(8'hBB);
    applyStimulus(8'h02);
    checkOutput("rdAddr", bus.RF_Address, 2);
    checkOutput("rdEnPulse", bus.RF_RdEn, 1);
    waitCycles(1);
    bus.RF_RdData = 8'h7E;
    bus.RF_RdData_Vaild = 1'b1;
    waitCycles(1);
    bus.RF_RdData_Vaild = 1'b0;
    waitTx(tx0 + 1, 20);
    waitCycles(2);
    checkOutput("rdCount", rdCnt - rd0, 1);
    checkOutput("rdTxCount", txCnt - tx0, 1);
    checkOutput("rdTxByte", txLog[tx0 % 64], 8'h7E);
    checkOutput("rdBusyLow", bus.BUSY, 0);

    $display("[TB] ALU CC,0A,03,02 -> 001E");
    wr0 = wrCnt; tx0 = txCnt; ae0 = aluEnCnt;
    applyStimulus(8'hCC);
    applyStimulus(8'h0A);
    applyStimulus(8'h03);
    applyStimulus(8'h02);
    checkOutput("aluFun", bus.ALU_FUN, 2);
    checkOutput("aluClkEnOn", bus.ALU_CLK_EN, 1);
    checkOutput("aluEnNotYet", bus.ALU_EN, 0);
    waitCycles(1);
    checkOutput("aluEnPulse", bus.ALU_EN, 1);
    bus.ALU_OUT = 16'h001E;
    bus.ALU_OUT_VALID = 1'b1;
    waitCycles(1);
    bus.ALU_OUT_VALID = 1'b0;
    waitTx(tx0 + 2, 20);
    waitCycles(2);
    checkOutput("opWrCount", wrCnt - wr0, 2);
    checkOutput("opAAddr", wrAddrLog[wr0 % 64], 0);
    checkOutput("opAData", wrDataLog[wr0 % 64], 8'h0A);
    checkOutput("opBAddr", wrAddrLog[(wr0 + 1) % 64], 1);
    checkOutput("opBData", wrDataLog[(wr0 + 1) % 64], 8'h03);
    checkOutput("aluEnCount", aluEnCnt - ae0, 1);
    checkOutput("aluTxCount", txCnt - tx0, 2);
    checkOutput("aluTxLsb", txLog[tx0 % 64], 8'h1E);
    checkOutput("aluTxMsb", txLog[(tx0 + 1) % 64], 8'h00);
    checkOutput("aluClkEnOff", bus.ALU_CLK_EN, 0);

    $display("[TB] ALU DD,00 with FIFO full");
    tx0 = txCnt;
    applyStimulus(8'hDD);
    applyStimulus(8'h00);
    waitCycles(1);
    checkOutput("ddAluEn", bus.ALU_EN, 1);
    bus.FIFO_FULL = 1'b1;
    bus.ALU_OUT = 16'hA55A;
    bus.ALU_OUT_VALID = 1'b1;
    waitCycles(1);
    bus.ALU_OUT_VALID = 1'b0;
    waitCycles(4);
    checkOutput("fullNoTx", txCnt - tx0, 0);
    checkOutput("fullVldLow", bus.TX_D_VLD, 0);
    checkOutput("fullDataHeld", bus.TX_P_DATA, 8'h5A);
    checkOutput("fullBusy", bus.BUSY, 1);
    bus.FIFO_FULL = 1'b0;
    waitTx(tx0 + 2, 20);
    waitCycles(3);
    checkOutput("fullTxCount", txCnt - tx0, 2);
    checkOutput("fullTxLsb", txLog[tx0 % 64], 8'h5A);
    checkOutput("fullTxMsb", txLog[(tx0 + 1) % 64], 8'hA5);
    checkOutput("fullViolations", fullViol, 0);

    $display("[TB] illegal byte 55");
    err0 = errCnt;
    applyStimulus(8'h55);
    checkOutput("illErrPulse", bus.CMD_ERR, 1);
    checkOutput("illBusyLow", bus.BUSY, 0);
    waitCycles(1);
    checkOutput("illErrDrop", bus.CMD_ERR, 0);
    checkOutput("illErrCount", errCnt - err0, 1);

    $display("[TB] read timeout BB,01");
    tx0 = txCnt; err0 = errCnt;
    applyStimulus(8'hBB);
    applyStimulus(8'h01);
    n = 0;
    while (!bus.CMD_ERR && n < 40) begin
      waitCycles(1);
      n++;
    end
    checkOutput("toCycles", n, 16);
    checkOutput("toBusyLow", bus.BUSY, 0);
    waitCycles(3);
    checkOutput("toErrCount", errCnt - err0, 1);
    checkOutput("toNoTx", txCnt - tx0, 0);

    $display("[TB] reset during OP_B");
    applyStimulus(8'hCC);
    applyStimulus(8'h0A);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("midRstWrData", bus.RF_WrData, 0);
    checkOutput("midRstWrEn", bus.RF_WrEn, 0);
    checkOutput("midRstAddr", bus.RF_Address, 0);
    checkOutput("midRstBusy", bus.BUSY, 0);
    checkOutput("midRstClkEn", bus.ALU_CLK_EN, 0);
    rst = 1'b0;
    wr0 = wrCnt;
    applyStimulus(8'hAA);
    applyStimulus(8'h01);
    applyStimulus(8'hFF);
    waitCycles(2);
    checkOutput("postRstWrCount", wrCnt - wr0, 1);
    checkOutput("postRstWrAddr", wrAddrLog[wr0 % 64], 1);
    checkOutput("postRstWrData", wrDataLog[wr0 % 64], 8'hFF);
    checkOutput("postRstBusy", bus.BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
Command sequencer in the REF_CLK domain. It takes synchronized UART RX bytes (COMMAND_IN / COMMAND_IN_vaild) and decodes 4 command frames. It drives the Register File (address, write, read), the ALU (function, enable, clock-gate enable), and the async TX FIFO write port. Responses (RF read data, ALU results) are pushed to the FIFO for UART TX.

Parameters:
DATA_WIDTH, 8, byte width of RX, RegFile and FIFO data
ADDR_WIDTH, 4, RegFile address width; address taken from RX byte bits [ADDR_WIDTH-1:0]
FUN_WIDTH, 4, ALU function code width; taken from RX byte bits [FUN_WIDTH-1:0]
TIMEOUT, 16, max cycles to wait for RdData_Vaild or ALU_OUT_VALID

Ports:
CLK  in  1  REF_CLK
RST  in  1  synchronous, active-high reset
RX_P_DATA  in  DATA_WIDTH  synchronized command/operand byte
RX_D_VLD  in  1  one-cycle pulse, byte valid
RF_Address  out  ADDR_WIDTH  RegFile address
RF_WrData  out  DATA_WIDTH  RegFile write data
RF_WrEn  out  1  RegFile write strobe
RF_RdEn  out  1  RegFile read strobe
RF_RdData  in  DATA_WIDTH  RegFile read data
RF_RdData_Vaild  in  1  RegFile read data valid
ALU_FUN  out  FUN_WIDTH  ALU function select
ALU_EN  out  1  ALU operation strobe
ALU_CLK_EN  out  1  CLK_GATE enable for ALU clock
ALU_OUT  in  2*DATA_WIDTH  ALU result
ALU_OUT_VALID  in  1  ALU result valid
TX_P_DATA  out  DATA_WIDTH  FIFO WR_DATA
TX_D_VLD  out  1  FIFO W_INC
FIFO_FULL  in  1  FIFO FULL
BUSY  out  1  high in any state other than IDLE
CMD_ERR  out  1  one-cycle pulse: illegal command or timeout

Behaviour:
- Clock and reset: single clock CLK; RST is synchronous, active-high. On RST, state goes to IDLE and all outputs and internal registers are 0.
- Registered outputs: every output is driven from a register.
- Strobes: RF_WrEn, RF_RdEn and ALU_EN are 1-cycle pulses, asserted in the cycle after the triggering byte is accepted.
- Byte acceptance: a byte is accepted only when RX_D_VLD=1 in a state that expects a byte. Bytes arriving in wait or TX states are dropped.
- Command 0xAA (RF write):
  - IDLE → WR_ADDR: latch the address byte.
  - WR_ADDR → WR_DATA: on the data byte, drive RF_WrData and pulse RF_WrEn.
  - WR_DATA → IDLE. No FIFO output.
- Command 0xBB (RF read):
  - RD_ADDR: on the address byte, pulse RF_RdEn, then go to RD_WAIT.
  - RD_WAIT: on RF_RdData_Vaild, capture RF_RdData, then go to TX_RF.
  - TX_RF: write 1 byte to the FIFO, then go to IDLE.
- Command 0xCC (ALU with operands):
  - OP_A: write the byte to RF address 0.
  - OP_B: write the byte to RF address 1.
  - ALU_FN: on the function byte, set ALU_FUN, set ALU_CLK_EN=1, then pulse ALU_EN one cycle later.
  - ALU_WAIT: on ALU_OUT_VALID, capture ALU_OUT, then go to TX_LSB.
  - TX_LSB sends ALU_OUT[7:0]; TX_MSB sends ALU_OUT[15:8]; then go to IDLE.
- Command 0xDD (ALU, no operands): IDLE → ALU_FN directly, then the same path as 0xCC.
- ALU_CLK_EN: held high from function-byte acceptance until the ALU result is captured or a timeout occurs; low otherwise.
- FIFO writes (TX states):
  - TX_D_VLD=1 for exactly one cycle per byte, only while FIFO_FULL=0.
  - While FIFO_FULL=1, TX_D_VLD=0 and TX_P_DATA is held stable; the FSM stalls with no byte loss.
- Illegal commands: any other byte in IDLE pulses CMD_ERR and the FSM stays in IDLE.
- Timeout:
  - A counter resets on entry to RD_WAIT or ALU_WAIT.
  - If the counter reaches TIMEOUT-1 without the valid signal: pulse CMD_ERR, set ALU_CLK_EN=0, go to IDLE, send nothing.
  - If valid and timeout occur in the same cycle, valid wins.
- Reset mid-frame: the frame is abandoned, and the next byte is decoded as a command.

Test Plan:
- RF write: bytes AA,05,3C → RF_Address=5, RF_WrData=0x3C, one RF_WrEn pulse; no TX_D_VLD; BUSY back to 0.
- RF read: bytes BB,02; RdData_Vaild returned 2 cycles later with 0x7E → RF_RdEn pulsed once; one FIFO write of 0x7E.
- ALU with operands: bytes CC,0A,03,02; ALU_OUT=0x001E → RF writes 0x0A@0 and 0x03@1; ALU_FUN=2; ALU_EN pulsed once; FIFO writes 0x1E then 0x00; ALU_CLK_EN low afterwards.
- FIFO full: command DD,00 with FIFO_FULL held 5 cycles during TX_LSB → no TX_D_VLD while full; then 2 writes with correct bytes, none lost or duplicated.
- Error paths:
  - Byte 0x55 in IDLE → one CMD_ERR pulse; state remains IDLE.
  - BB,01 with no RdData_Vaild → CMD_ERR at cycle TIMEOUT; IDLE; no FIFO write.
- Reset mid-frame: RST during OP_B of CC frame → all outputs 0 next cycle; following AA,01,FF executes as a normal write.
